// File: rtl/pipe_stage_reg_pkg.sv
// Shared constants for the core's inter-stage registers: stage payload widths
// and the bubble (NOP) encoding that flushed or drained slots carry.
package pipe_stage_reg_pkg;

  localparam int PC_W    = 32;
  localparam int IR_W    = 32;
  localparam int STAGE_W = PC_W + IR_W;

  // sll $0,$0,0 -- the all-zero instruction word decodes as nop
  localparam logic [IR_W-1:0]    NOP_IR    = '0;
  localparam logic [STAGE_W-1:0] BUBBLE_FD = {{PC_W{1'b0}}, NOP_IR};

endpackage

// File: rtl/pipe_slot.sv
// One storage slot of a pipeline stage: payload register plus valid bit.
// clear (bubble load) wins over load; with neither asserted the slot holds.
module pipe_slot
  import pipe_stage_reg_pkg::*;
#(
  parameter int                DATA_W     = STAGE_W,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = '0
) (
  input  logic              clk,
  input  logic              load,
  input  logic              clear,
  input  logic [DATA_W-1:0] d,
  output logic              valid,
  output logic [DATA_W-1:0] q
);

  always_ff @(posedge clk) begin
    if (clear) begin
      valid <= 1'b0;
      q     <= BUBBLE_VAL;
    end else if (load) begin
      valid <= 1'b1;
      q     <= d;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with optional two-entry skid buffer,
// synchronous flush and bubble insertion on flush or drain.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int                DATA_W     = STAGE_W,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = BUBBLE_FD[DATA_W-1:0],
  parameter int                SKID       = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  // Encoding doubles as the entry count.
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_FULL  = 2'd1;
  localparam logic [1:0] ST_SKID  = 2'd2;

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic              main_load;
  logic              main_clear;
  logic              skid_load;
  logic              skid_clear;
  logic              main_valid;
  logic              skid_valid;
  logic [DATA_W-1:0] main_d;
  logic [DATA_W-1:0] main_q;
  logic [DATA_W-1:0] skid_q;

  always_comb begin
    main_load  = 1'b0;
    main_clear = 1'b0;
    skid_load  = 1'b0;
    skid_clear = 1'b0;
    main_d     = in_data;
    state_nxt  = state;
    if (reset || flush) begin
      main_clear = 1'b1;
      skid_clear = 1'b1;
      state_nxt  = ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (in_valid) begin
            main_load = 1'b1;
            state_nxt = ST_FULL;
          end
        end
        ST_FULL: begin
          if (in_valid && out_ready) begin
            main_load = 1'b1;
          end else if (in_valid && (SKID != 0)) begin
            skid_load = 1'b1;
            state_nxt = ST_SKID;
          end else if (!in_valid && out_ready) begin
            main_clear = 1'b1;
            state_nxt  = ST_EMPTY;
          end
        end
        ST_SKID: begin
          if (out_ready) begin
            main_load  = 1'b1;
            main_d     = skid_q;
            skid_clear = 1'b1;
            state_nxt  = ST_FULL;
          end
        end
        default: begin
          main_clear = 1'b1;
          skid_clear = 1'b1;
          state_nxt  = ST_EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    state <= state_nxt;
  end

  pipe_slot #(
    .DATA_W     (DATA_W),
    .BUBBLE_VAL (BUBBLE_VAL)
  ) u_main (
    .clk   (clk),
    .load  (main_load),
    .clear (main_clear),
    .d     (main_d),
    .valid (main_valid),
    .q     (main_q)
  );

  generate
    if (SKID != 0) begin : g_skid
      pipe_slot #(
        .DATA_W     (DATA_W),
        .BUBBLE_VAL (BUBBLE_VAL)
      ) u_skid (
        .clk   (clk),
        .load  (skid_load),
        .clear (skid_clear),
        .d     (in_data),
        .valid (skid_valid),
        .q     (skid_q)
      );
      // Registered ready: no combinational path from out_ready.
      assign in_ready = !skid_valid;
    end else begin : g_noskid
      assign skid_valid = 1'b0;
      assign skid_q     = BUBBLE_VAL;
      assign in_ready   = !main_valid || out_ready;
    end
  endgenerate

  assign out_valid = main_valid;
  assign out_data  = main_q;
  assign occupancy = state;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a skid and a no-skid instance share stimulus,
// each checked against a queue model of a bounded FIFO with flush.
module tb_pipe_stage_reg;
  import pipe_stage_reg_pkg::*;

  localparam int          W    = STAGE_W;
  localparam logic [63:0] BUB1 = 64'h0;
  localparam logic [63:0] BUB0 = 64'h0000_0000_FFFF_FFFF;

  logic         clk = 1'b0;
  logic         reset, flush, in_valid, out_ready;
  logic [W-1:0] in_data;

  logic         rdy1, ov1, rdy0, ov0;
  logic [W-1:0] od1, od0;
  logic [1:0]   occ1, occ0;

  int compared   = 0;
  int mismatched = 0;
  bit run_chk    = 1'b0;
  int seq        = 0;

  logic [W-1:0] q1[$];
  logic [W-1:0] q0[$];

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(W), .BUBBLE_VAL(BUB1), .SKID(1)) u_skid (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy1), .in_data(in_data),
    .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .occupancy(occ1)
  );

  pipe_stage_reg #(.DATA_W(W), .BUBBLE_VAL(BUB0), .SKID(0)) u_noskid (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy0), .in_data(in_data),
    .out_valid(ov0), .out_ready(out_ready), .out_data(od0), .occupancy(occ0)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Monitor + model: compare outputs mid-cycle, then advance each model with
  // the inputs that the coming posedge will see.
  always @(negedge clk) begin
    if (run_chk) begin
      logic        e_rdy1, e_rdy0, e_ov1, e_ov0;
      logic [63:0] e_d1, e_d0;
      e_ov1  = (q1.size() > 0);
      e_d1   = e_ov1 ? q1[0] : BUB1;
      e_rdy1 = (q1.size() < 2);
      e_ov0  = (q0.size() > 0);
      e_d0   = e_ov0 ? q0[0] : BUB0;
      e_rdy0 = (q0.size() == 0) || out_ready;

      chk("skid_out_valid", {63'b0, ov1}, {63'b0, e_ov1});
      chk("skid_out_data", od1, e_d1);
      chk("skid_occupancy", {62'b0, occ1}, 64'(q1.size()));
      chk("skid_in_ready", {63'b0, rdy1}, {63'b0, e_rdy1});
      chk("noskid_out_valid", {63'b0, ov0}, {63'b0, e_ov0});
      chk("noskid_out_data", od0, e_d0);
      chk("noskid_occupancy", {62'b0, occ0}, 64'(q0.size()));
      chk("noskid_in_ready", {63'b0, rdy0}, {63'b0, e_rdy0});

      if (reset || flush) begin
        q1.delete();
        q0.delete();
      end else begin
        if (e_ov1 && out_ready) void'(q1.pop_front());
        if (in_valid && e_rdy1) q1.push_back(in_data);
        if (e_ov0 && out_ready) void'(q0.pop_front());
        if (in_valid && e_rdy0) q0.push_back(in_data);
      end
    end
  end

  task automatic step(input logic iv, input logic [W-1:0] d, input logic ordy,
                      input logic fl, input logic rst);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    reset     = rst;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] fresh();
    seq++;
    return {$urandom(), 32'(seq)};
  endfunction

  initial begin
    // Reset with a live-looking input that must be ignored.
    step(1'b1, 64'h0000_3000_2402_0001, 1'b0, 1'b0, 1'b1);
    run_chk = 1'b1;
    step(1'b1, 64'h0000_3000_2402_0001, 1'b0, 1'b0, 1'b1);

    // Streaming A,B,C with downstream always ready, then drain.
    step(1'b1, 64'hA, 1'b1, 1'b0, 1'b0);
    step(1'b1, 64'hB, 1'b1, 1'b0, 1'b0);
    step(1'b1, 64'hC, 1'b1, 1'b0, 1'b0);
    step(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);

    // Backpressure: fill the skid, offer C early, then release.
    step(1'b1, 64'h1A, 1'b0, 1'b0, 1'b0);
    step(1'b1, 64'h1B, 1'b0, 1'b0, 1'b0);
    step(1'b1, 64'h1C, 1'b0, 1'b0, 1'b0);
    step(1'b1, 64'h1C, 1'b1, 1'b0, 1'b0);
    step(1'b1, 64'h1C, 1'b1, 1'b0, 1'b0);
    step(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);

    // Flush while the skid holds two entries, with an input offered.
    step(1'b1, 64'h2D, 1'b0, 1'b0, 1'b0);
    step(1'b1, 64'h2E, 1'b0, 1'b0, 1'b0);
    step(1'b1, 64'h2F, 1'b0, 1'b1, 1'b0);
    step(1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);

    // Single payload drained with nothing behind it.
    step(1'b1, 64'h1234, 1'b0, 1'b0, 1'b0);
    step(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 64'h0, 1'b0, 1'b0, 1'b0);

    // Randomized traffic with varying pressure, plus rare flush/reset.
    for (int i = 0; i < 3000; i++) begin
      int vp, rp;
      vp = (i / 500) % 3 == 0 ? 90 : ((i / 500) % 3 == 1 ? 50 : 20);
      rp = (i / 250) % 3 == 0 ? 85 : ((i / 250) % 3 == 1 ? 40 : 15);
      step($urandom_range(99) < vp, fresh(), $urandom_range(99) < rp,
           $urandom_range(99) < 3, $urandom_range(199) < 1);
    end

    step(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
    run_chk = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
